// File: rtl/spram_fifo_pkg.sv
// rtl/spram_fifo_pkg.sv - shared constants and RAM port operation select for spram_fifo_ctrl
package spram_fifo_pkg;

  // Output buffer entries that sit behind the RAM read port.
  localparam int OB_DEPTH = 2;

  // Which access owns the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ram_op_e;

endpackage

// File: rtl/spram.sv
// rtl/spram.sv - single-port RAM, registered read address, write-first
module spram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr;

  // One access per cycle; the address is captured so data appears the following cycle.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      r_addr <= i_addr;
    end
  end

  // Reading through the stored address returns freshly written data (write-first).
  assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/spram_fifo_ctrl.sv
// rtl/spram_fifo_ctrl.sv - FIFO over one single-port RAM with a 2-entry output buffer; option SPRAM_FIFO_BYPASS_EN
module spram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count
);

  import spram_fifo_pkg::*;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_pend;
  logic [1:0]            r_ob_cnt;
  logic [DATA_WIDTH-1:0] r_ob_data [OB_DEPTH];

  logic [1:0]            w_ob_fill;
  logic                  w_rd_req;
  logic                  w_s_ready;
  logic                  w_s_fire;
  logic                  w_bypass;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ob_slot;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  ram_op_e               w_op;

  // Output-buffer slots already spoken for, including a read still in flight.
  assign w_ob_fill = r_ob_cnt + {1'b0, r_rd_pend};
  assign w_rd_req  = (r_ram_cnt != '0) && (w_ob_fill < 2'd2);

  // A write normally wins the port; the read takes it only when the output side would starve.
  assign w_s_ready = (r_ram_cnt < (ADDR_WIDTH+1)'(FIFO_DEPTH)) &&
                     !(w_rd_req && (w_ob_fill == 2'd0));
  assign w_s_fire  = s_valid && w_s_ready;

`ifdef SPRAM_FIFO_BYPASS_EN
  assign w_bypass = w_s_fire && (r_ram_cnt == '0) && !r_rd_pend && (r_ob_cnt < 2'd2);
`else
  assign w_bypass = 1'b0;
`endif

  // Select the single RAM access for this cycle.
  always_comb begin
    w_op = IDLE;
    if (w_s_fire && !w_bypass) begin
      w_op = WRITE;
    end else if (w_rd_req) begin
      w_op = READ;
    end
  end

  assign w_ram_addr  = (w_op == WRITE) ? r_wr_ptr : r_rd_ptr;
  assign w_pop       = (r_ob_cnt != 2'd0) && m_ready;
  assign w_push      = r_rd_pend || w_bypass;
  assign w_push_data = r_rd_pend ? w_ram_rdata : s_data;
  // Slot the pushed word lands in once this cycle's pop has shifted the buffer.
  assign w_ob_slot   = r_ob_cnt[1] | (r_ob_cnt[0] & ~w_pop);

  spram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_op != IDLE),
    .i_we    (w_op == WRITE),
    .i_addr  (w_ram_addr),
    .i_wdata (s_data),
    .o_rdata (w_ram_rdata)
  );

  // RAM-side bookkeeping: pointers, occupancy and the read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      case (w_op)
        WRITE: begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
          r_ram_cnt <= r_ram_cnt + 1'b1;
        end
        READ: begin
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          r_ram_cnt <= r_ram_cnt - 1'b1;
        end
        default: ;
      endcase
      r_rd_pend <= (w_op == READ);
    end
  end

  // Output buffer: entry 0 is the oldest; pop shifts, push fills the next free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ob_cnt <= 2'd0;
      for (int i = 0; i < OB_DEPTH; i++) begin
        r_ob_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_ob_data[0] <= r_ob_data[1];
      end
      if (w_push) begin
        r_ob_data[w_ob_slot] <= w_push_data;
      end
      r_ob_cnt <= r_ob_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Internal state is already held clear in reset; only the visible ready needs gating.
  assign s_ready = rst_n && w_s_ready;
  assign m_valid = (r_ob_cnt != 2'd0);
  assign m_data  = r_ob_data[0];
  assign count   = r_ram_cnt + (ADDR_WIDTH+1)'(r_rd_pend) + (ADDR_WIDTH+1)'(r_ob_cnt);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb/tb_spram_fifo_ctrl.sv - directed vector bench for spram_fifo_ctrl (default build)
module tb_spram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [4:0] count;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic fire_s;
  logic fire_m;

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_sr;
    logic       e_mv;
    logic [7:0] e_md;
    int         e_cnt;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  spram_fifo_ctrl #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .ADDR_WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample mid-cycle and keep the scoreboard.
  task automatic drive(input logic sv, input logic [7:0] sd, input logic mr);
    logic [7:0] exp_w;
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    check("count_vs_model", int'(count), q.size());
    fire_s = s_valid && s_ready;
    fire_m = m_valid && m_ready;
    if (fire_m) begin
      if (q.size() == 0) begin
        check("pop_on_empty", 1, 0);
      end else begin
        exp_w = q.pop_front();
        check("order", int'(m_data), int'(exp_w));
      end
    end
    if (fire_s) q.push_back(sd);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      drive(1'b0, 8'h00, 1'b1);
      cyc++;
    end
    check(name, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single word 0xA5, then two back-to-back words with a stalled consumer
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 2};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].sv, tbl[i].sd, tbl[i].mr);
      check($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_sr);
      check($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].e_mv);
      check($sformatf("vec%0d_count", i), int'(count), tbl[i].e_cnt);
      if (tbl[i].e_mv) check($sformatf("vec%0d_m_data", i), int'(m_data), int'(tbl[i].e_md));
    end

    // fill to capacity with a stalled consumer, hold, then drain in order
    begin
      int w = 0;
      int cyc = 0;
      while (w < 18 && cyc < 200) begin
        drive(1'b1, 8'(w), 1'b0);
        if (fire_s) w++;
        cyc++;
      end
      check("fill_accepts", w, 18);
      drive(1'b1, 8'hEE, 1'b0);
      check("full_s_ready", s_ready, 0);
      check("full_count", int'(count), 18);
      for (int k = 0; k < 10; k++) begin
        drive(1'b0, 8'h00, 1'b0);
        check("hold_m_valid", m_valid, 1);
        check("hold_m_data", int'(m_data), 0);
      end
      drain("fill_drain");
      drive(1'b0, 8'h00, 1'b1);
      check("fill_empty_count", int'(count), 0);
    end

    // continuous traffic on both sides
    begin
      int run = 0;
      int max_run = 0;
      int pops = 0;
      logic [7:0] seq = 8'h40;
      for (int c = 0; c < 300; c++) begin
        drive(1'b1, seq, 1'b1);
        if (fire_s) seq++;
        if (fire_m) pops++;
        check("cont_count_le18", int'(count <= 5'd18), 1);
        if (c >= 10) begin
          run = m_valid ? 0 : run + 1;
          if (run > max_run) max_run = run;
        end
      end
      check("cont_max_stall_le4", int'(max_run <= 4), 1);
      check("cont_pops_ge50", int'(pops >= 50), 1);
      drain("cont_drain");
    end

    // random handshakes, 1000 words
    begin
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      logic sv;
      while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
        sv = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(sv, 8'(sent), 1'($urandom_range(0, 1)));
        if (fire_s) sent++;
        if (fire_m) recv++;
        cyc++;
      end
      check("rand_sent", sent, 1000);
      check("rand_recv", recv, 1000);
    end

    // reset in the middle of operation
    begin
      int w = 0;
      int cyc = 0;
      while (w < 7 && cyc < 100) begin
        drive(1'b1, 8'(8'h70 + w), 1'b0);
        if (fire_s) w++;
        cyc++;
      end
      drive(1'b0, 8'h00, 1'b0);
      check("pre_reset_count", int'(count), 7);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_count", int'(count), 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      fire_s = 1'b0;
      while (!fire_s && cyc < 20) begin
        drive(1'b1, 8'h3C, 1'b1);
        cyc++;
      end
      check("post_rst_accept", fire_s, 1);
      cyc = 0;
      fire_m = 1'b0;
      while (!fire_m && cyc < 20) begin
        drive(1'b0, 8'h00, 1'b1);
        cyc++;
      end
      check("post_rst_pop", fire_m, 1);
      check("post_rst_first", int'(m_data), 8'h3C);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spram_fifo_ctrl.md
SPRAM_FIFO_CTRL -- requirements
Module: spram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, RAM entries; power of two, >=4.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH), RAM address width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  upstream data valid.
REQ-007 SHALL have port s_ready  output  1  block can accept s_data this cycle.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port m_valid  output  1  m_data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  downstream payload, driven from a register.
REQ-012 SHALL have port count  output  ADDR_WIDTH+1  total entries held (RAM + read in flight + output buffer).

Function
REQ-013 SHALL store payloads in one single-port RAM: one access (read or write) per cycle, registered read address, read data valid the cycle after the read is issued.
REQ-014 SHALL keep wr_ptr and rd_ptr of ADDR_WIDTH bits that wrap from FIFO_DEPTH-1 to 0, plus ram_cnt in 0..FIFO_DEPTH.
REQ-015 SHALL keep a 2-entry output buffer (ob_cnt 0..2) and a 1-bit rd_pend flag marking a RAM read whose data arrives this cycle.
REQ-016 SHALL raise rd_req = (ram_cnt!=0) && (ob_cnt+rd_pend<2).
REQ-017 SHALL drive s_ready = (ram_cnt<FIFO_DEPTH) && !(rd_req && ob_cnt+rd_pend==0); the read wins only when the output side is starving, otherwise the write wins.
REQ-018 SHALL write s_data to RAM[wr_ptr] and increment wr_ptr when s_valid&&s_ready; otherwise, if rd_req, SHALL issue a read of RAM[rd_ptr], increment rd_ptr and set rd_pend for the next cycle.
REQ-019 SHALL push RAM read data into the output buffer in the cycle rd_pend=1; push and pop in the same cycle SHALL both take effect.
REQ-020 SHALL drive m_valid = (ob_cnt!=0) and m_data = oldest output-buffer entry; pop on m_valid&&m_ready.
REQ-021 SHALL preserve strict FIFO order; no entry is lost or duplicated under any s_valid/m_ready pattern.
REQ-022 SHALL update ram_cnt by +1 on write, -1 on read issue, unchanged if neither; count = ram_cnt+rd_pend+ob_cnt, max FIFO_DEPTH+2.
REQ-023 SHALL, with the bypass feature absent, give 3 cycles from s-side accept (cycle 0) to m_valid (cycle 3) on an empty block.
REQ-024 SHALL, when full (ram_cnt==FIFO_DEPTH), hold s_ready=0 until a read is issued; s_data SHALL be ignored while s_ready=0.
REQ-025 SHALL keep m_data stable while m_valid&&!m_ready.

Reset
REQ-026 SHALL, while rst_n=0, clear wr_ptr, rd_ptr, ram_cnt, rd_pend, ob_cnt and output-buffer data to 0, and force s_ready=0, m_valid=0, count=0.
REQ-027 SHALL discard all held and in-flight entries on reset mid-operation; RAM contents are not cleared and are never read before being rewritten.
REQ-028 SHALL accept data from the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL honour macro SPRAM_FIFO_BYPASS_EN: when defined, an accepted write with ram_cnt==0 && rd_pend==0 && ob_cnt<2 goes directly into the output buffer (m_valid in cycle 1), with no RAM write and no ram_cnt change.
REQ-030 SHALL, without SPRAM_FIFO_BYPASS_EN, route every write through RAM per REQ-018/023.

Structure
REQ-031 SHALL place constant OB_DEPTH=2 and the priority-selection enum (IDLE, WRITE, READ) in package spram_fifo_pkg.
REQ-032 SHALL instantiate sub-module spram (write-first, single-port) for storage; the controller and output buffer remain in spram_fifo_ctrl.

Verification
REQ-033 Single word 0xA5 into an empty block, m_ready=1 -> m_data=0xA5 with m_valid at cycle 3 (cycle 1 with SPRAM_FIFO_BYPASS_EN); count returns to 0.
REQ-034 Push 18 words (0x00..0x11), m_ready=0 -> s_ready falls after the 18th accept, count=18; then drain -> 0x00..0x11 in order.
REQ-035 Continuous s_valid=1 and m_ready=1 after the pipeline fills -> no entry lost or reordered, count never exceeds 18, m_valid never stalls permanently.
REQ-036 Random s_valid/m_ready (50%) with 1000 words -> scoreboard matches exactly and rd_ptr/wr_ptr wrap at least 50 times.
REQ-037 Assert rst_n=0 with count=7 -> m_valid=0, s_ready=0, count=0 on the same edge; after release, new word 0x3C emerges first.
REQ-038 m_valid=1 held with m_ready=0 for 10 cycles -> m_data unchanged throughout.
